// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO used as the per-lane elastic
// buffer between TLP producer and consumer stages.
//
// Parameters:
//   DATA_WIDTH - width of each stored word
//   ADDR_WIDTH - log2 of the depth (DEPTH = 2**ADDR_WIDTH)
//
// Ports:
//   clk          - single clock, all state updates on its rising edge
//   reset        - asynchronous, active-high reset
//   data_a       - write data, sampled when push is accepted
//   push / pop   - write / read requests
//   af_thresh    - almost-full threshold (fill_count >= af_thresh)
//   ae_thresh    - almost-empty threshold (0 < fill_count <= ae_thresh)
//   err_clr      - synchronous clear of the sticky error flags
//   q_b          - registered read data, one cycle after an accepted pop
//   valid_b      - q_b was updated by an accepted pop on the last edge
//   fill_count   - current occupancy, 0..DEPTH
//   full, empty, almost_full, almost_empty - status flags from fill_count
//   overflow     - sticky, a push was dropped because the FIFO was full
//   underflow    - sticky, a pop was ignored because the FIFO was empty
//   error        - overflow | underflow
module fifo_param #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] q_b,
    output logic                  valid_b,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  error
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    // A push into a full FIFO is still accepted when a pop frees a slot on
    // the same edge; a pop from an empty FIFO is never accepted, so there is
    // no fall-through of same-cycle write data.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    // Status flags are purely combinational from the registered count, so
    // they track the thresholds immediately when those change.
    assign full         = (fill_count == DEPTH_CNT);
    assign empty        = (fill_count == '0);
    assign almost_full  = (fill_count >= af_thresh);
    assign almost_empty = ~empty & (fill_count <= ae_thresh);
    assign error        = overflow | underflow;

    // Storage array has no reset: contents are meaningless after reset since
    // both pointers and the count return to zero.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_a;
        end
    end

    // Pointers wrap naturally; the count is kept separately so that full and
    // empty never need an extra pointer bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   fill_count <= fill_count + (ADDR_WIDTH + 1)'(1);
                2'b01:   fill_count <= fill_count - (ADDR_WIDTH + 1)'(1);
                default: fill_count <= fill_count;
            endcase
        end
    end

    // Read port: q_b holds its last value unless a pop is accepted, and
    // valid_b is a single-cycle strobe marking that update. When full with a
    // simultaneous push and pop, rd_ptr == wr_ptr and the old word is read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_b     <= '0;
            valid_b <= 1'b0;
        end else begin
            valid_b <= pop_ok;
            if (pop_ok) begin
                q_b <= mem[rd_ptr];
            end
        end
    end

    // Sticky error flags: a new error event takes priority over err_clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push & ~push_ok) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (pop & ~pop_ok) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: self-checking bench for fifo_param with default parameters
// (4-bit words, depth 8). A queue-based reference model tracks the expected
// contents and flags; a compare process checks every DUT output against it on
// each falling edge, and the directed sequences add hand-computed literal
// expectations.
module tb_fifo_param;

    localparam int DW    = 4;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] data_a = '0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [AW:0]   af_thresh = 4'd6;
    logic [AW:0]   ae_thresh = 4'd2;
    logic          err_clr = 1'b0;
    logic [DW-1:0] q_b;
    logic          valid_b;
    logic [AW:0]   fill_count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;
    logic          error;

    int n_vectors = 0;
    int n_miscompares = 0;
    bit check_en = 1'b0;

    // Reference model state
    logic [DW-1:0] model_fifo[$];
    logic [DW-1:0] model_q = '0;
    bit            model_valid = 1'b0;
    bit            model_ovf = 1'b0;
    bit            model_udf = 1'b0;

    fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_a       (data_a),
        .push         (push),
        .pop          (pop),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .err_clr      (err_clr),
        .q_b          (q_b),
        .valid_b      (valid_b),
        .fill_count   (fill_count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow),
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, then return just after the rising edge.
    task automatic applyStimulus(input logic p, input logic po,
                                 input logic [DW-1:0] d, input logic ec);
        push    = p;
        pop     = po;
        data_a  = d;
        err_clr = ec;
        @(posedge clk);
        #1;
    endtask

    // Model: a queue of stored words. Acceptance is decided on the occupancy
    // before the edge; the pop is taken from the front before the push is
    // appended so a full FIFO can pass data through.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_fifo.delete();
            model_q     = '0;
            model_valid = 1'b0;
            model_ovf   = 1'b0;
            model_udf   = 1'b0;
        end else begin
            int  n;
            bit  take_pop;
            bit  take_push;
            n         = model_fifo.size();
            take_pop  = pop && (n > 0);
            take_push = push && ((n < DEPTH) || pop);
            model_valid = take_pop;
            if (take_pop) model_q = model_fifo.pop_front();
            if (take_push) model_fifo.push_back(data_a);
            if (push && !take_push) model_ovf = 1'b1;
            else if (err_clr) model_ovf = 1'b0;
            if (pop && !take_pop) model_udf = 1'b1;
            else if (err_clr) model_udf = 1'b0;
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            int n;
            n = model_fifo.size();
            checkOutput("q_b", 32'(q_b), 32'(model_q));
            checkOutput("valid_b", 32'(valid_b), 32'(model_valid));
            checkOutput("fill_count", 32'(fill_count), n);
            checkOutput("full", 32'(full), 32'(n == DEPTH));
            checkOutput("empty", 32'(empty), 32'(n == 0));
            checkOutput("almost_full", 32'(almost_full), 32'(n >= int'(af_thresh)));
            checkOutput("almost_empty", 32'(almost_empty), 32'((n != 0) && (n <= int'(ae_thresh))));
            checkOutput("overflow", 32'(overflow), 32'(model_ovf));
            checkOutput("underflow", 32'(underflow), 32'(model_udf));
            checkOutput("error", 32'(error), 32'(model_ovf || model_udf));
        end
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        #1 reset = 1'b1;
        #1;
        check_en = 1'b1;
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_count", 32'(fill_count), 32'd0);
        checkOutput("rst_q", 32'(q_b), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        #20 reset = 1'b0;
        @(posedge clk);
        #1;

        // Test 1: push 1..8, almost_full at 6, full at 8
        $display("[TB] test 1: fill");
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 1'b0, DW'(i), 1'b0);
            checkOutput("t1_count", 32'(fill_count), i);
            checkOutput("t1_af", 32'(almost_full), 32'(i >= 6));
        end
        checkOutput("t1_full", 32'(full), 32'd1);
        checkOutput("t1_ovf", 32'(overflow), 32'd0);

        // Test 2: overflow, drain, clear
        $display("[TB] test 2: overflow and drain");
        applyStimulus(1'b1, 1'b0, 4'hF, 1'b0);
        checkOutput("t2_count", 32'(fill_count), 32'd8);
        checkOutput("t2_ovf", 32'(overflow), 32'd1);
        checkOutput("t2_err", 32'(error), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b1, 4'h0, 1'b0);
            checkOutput("t2_q", 32'(q_b), i);
            checkOutput("t2_valid", 32'(valid_b), 32'd1);
        end
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
        checkOutput("t2_err_clr", 32'(error), 32'd0);
        checkOutput("t2_valid_idle", 32'(valid_b), 32'd0);

        // Test 3: underflow, err_clr loses to a new underflow
        $display("[TB] test 3: underflow");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 4'h0, 1'b0);
            checkOutput("t3_q_hold", 32'(q_b), 32'h8);
            checkOutput("t3_valid", 32'(valid_b), 32'd0);
            checkOutput("t3_udf", 32'(underflow), 32'd1);
        end
        applyStimulus(1'b0, 1'b1, 4'h0, 1'b1);
        checkOutput("t3_udf_wins", 32'(underflow), 32'd1);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
        checkOutput("t3_udf_clr", 32'(underflow), 32'd0);

        // Test 4: full with simultaneous push+pop across pointer wrap
        $display("[TB] test 4: full push+pop");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, DW'(8 + i), 1'b0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 1'b1, DW'(k), 1'b0);
            checkOutput("t4_count", 32'(fill_count), 32'd8);
            checkOutput("t4_q", 32'(q_b), (k < 8) ? (8 + k) : (k - 8));
        end
        checkOutput("t4_ovf", 32'(overflow), 32'd0);
        for (int k = 2; k < 10; k++) begin
            applyStimulus(1'b0, 1'b1, 4'h0, 1'b0);
            checkOutput("t4_drain", 32'(q_b), k);
        end

        // Test 5: push+pop on empty, no fall-through
        $display("[TB] test 5: empty push+pop");
        applyStimulus(1'b1, 1'b1, 4'h5, 1'b0);
        checkOutput("t5_count", 32'(fill_count), 32'd1);
        checkOutput("t5_udf", 32'(underflow), 32'd1);
        checkOutput("t5_valid", 32'(valid_b), 32'd0);
        checkOutput("t5_q_hold", 32'(q_b), 32'h9);
        applyStimulus(1'b0, 1'b1, 4'h0, 1'b1);
        checkOutput("t5_q", 32'(q_b), 32'h5);
        checkOutput("t5_valid2", 32'(valid_b), 32'd1);

        // Test 6: asynchronous reset mid-cycle
        $display("[TB] test 6: async reset");
        ae_thresh = 4'd2;
        applyStimulus(1'b1, 1'b0, 4'hA, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'hB, 1'b0);
        checkOutput("t6_ae2", 32'(almost_empty), 32'd1);
        applyStimulus(1'b1, 1'b0, 4'hC, 1'b0);
        checkOutput("t6_ae3", 32'(almost_empty), 32'd0);
        push = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("t6_count", 32'(fill_count), 32'd0);
        checkOutput("t6_empty", 32'(empty), 32'd1);
        checkOutput("t6_q", 32'(q_b), 32'd0);
        checkOutput("t6_ae", 32'(almost_empty), 32'd0);
        checkOutput("t6_error", 32'(error), 32'd0);
        #3 reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 4'h0, 1'b0);
        checkOutput("t6_udf", 32'(underflow), 32'd1);
        checkOutput("t6_valid", 32'(valid_b), 32'd0);

        // Threshold corners: zero and beyond-depth thresholds
        $display("[TB] threshold corners");
        af_thresh = 4'd0;
        ae_thresh = 4'd0;
        #1;
        checkOutput("th_af0", 32'(almost_full), 32'd1);
        applyStimulus(1'b1, 1'b0, 4'h3, 1'b1);
        checkOutput("th_ae0", 32'(almost_empty), 32'd0);
        af_thresh = 4'd9;
        ae_thresh = 4'd15;
        #1;
        checkOutput("th_ae15", 32'(almost_empty), 32'd1);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, DW'(i), 1'b0);
        checkOutput("th_full", 32'(full), 32'd1);
        checkOutput("th_af9", 32'(almost_full), 32'd0);
        checkOutput("th_ae15_full", 32'(almost_empty), 32'd1);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
